// File: rtl/mem_access_unit.sv
// Multi-cycle MEM stage: drives a req/gnt/rvalid data bus, splits misaligned
// accesses into two beats and returns the aligned, extended load result.
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter bit LANE_SWAP      = 1'b1,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_req_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_err_i
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, REQ1, RSP1, REQ2, RSP2, DONE} state_e;

    state_e            state_q;
    logic [OW-1:0]     off_q;
    logic [1:0]        size_q;
    logic              uns_q, load_q, wreg_q, split_q, err_q;
    logic [4:0]        wd_q;
    logic [ADDR_W-1:0] addr2_q, baddr_q;
    logic [NB-1:0]     sel2_q, sel_q;
    logic [DATA_W-1:0] wdat2_q, rbuf_q, bwdata_q;
    logic              req_q, we_q;

    logic              mem_op, split_d, bad_d;
    logic [OW-1:0]     off_d;
    int                nbytes_d, p, nbq, nbits;
    logic [ADDR_W-1:0] base_d;
    logic [NB-1:0]     sel1_d, sel2_d;
    logic [DATA_W-1:0] wd1_d, wd2_d, ext;

    function automatic int lane(input int k);
        return LANE_SWAP ? NB - 1 - k : k;
    endfunction

    // Issue-time decode: both beats are laid out while the op sits in EX/MEM
    always_comb begin
        mem_op   = ex_valid_i & (is_load_i | is_store_i);
        off_d    = addr_i[OW-1:0];
        nbytes_d = 1 << size_i;
        split_d  = (int'(off_d) + nbytes_d) > NB;
        bad_d    = (nbytes_d > NB) | (split_d & !MISALIGN_SPLIT);
        base_d   = addr_i & ~ADDR_W'(NB - 1);
        sel1_d   = '0;
        sel2_d   = '0;
        wd1_d    = '0;
        wd2_d    = '0;
        p        = 0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes_d) begin
                p = int'(off_d) + i;
                if (p < NB) begin
                    sel1_d[lane(p)] = 1'b1;
                    wd1_d[8*lane(p) +: 8] = is_load_i ? 8'h00 : reg2_i[8*i +: 8];
                end else begin
                    sel2_d[lane(p-NB)] = 1'b1;
                    wd2_d[8*lane(p-NB) +: 8] = is_load_i ? 8'h00 : reg2_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        nbq   = 1 << size_q;
        nbits = 8 * nbq;
        ext   = rbuf_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits) ext[i] = uns_q ? 1'b0 : rbuf_q[nbits-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            load_q   <= 1'b0;
            wreg_q   <= 1'b0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            addr2_q  <= '0;
            sel2_q   <= '0;
            wdat2_q  <= '0;
            rbuf_q   <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= '0;
            sel_q    <= '0;
            bwdata_q <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: if (mem_op) begin
                    off_q   <= off_d;
                    size_q  <= size_i;
                    uns_q   <= unsigned_i;
                    load_q  <= is_load_i;
                    wd_q    <= wd_i;
                    wreg_q  <= wreg_i;
                    split_q <= split_d;
                    addr2_q <= base_d + ADDR_W'(NB);
                    sel2_q  <= sel2_d;
                    wdat2_q <= wd2_d;
                    rbuf_q  <= '0;
                    if (bad_d) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                    end else begin
                        state_q  <= REQ1;
                        req_q    <= 1'b1;
                        we_q     <= !is_load_i;
                        baddr_q  <= base_d;
                        sel_q    <= sel1_d;
                        bwdata_q <= wd1_d;
                    end
                end
                REQ1, REQ2: if (bus_gnt_i) begin
                    req_q    <= 1'b0;
                    we_q     <= 1'b0;
                    sel_q    <= '0;
                    bwdata_q <= '0;
                    state_q  <= (state_q == REQ1) ? RSP1 : RSP2;
                end
                RSP1: if (bus_rvalid_i) begin
                    for (int o = 0; o < NB; o++) begin
                        if (o >= int'(off_q) && o < int'(off_q) + nbq)
                            rbuf_q[8*(o-int'(off_q)) +: 8] <= bus_rdata_i[8*lane(o) +: 8];
                    end
                    if (bus_err_i) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (split_q) begin
                        state_q  <= REQ2;
                        req_q    <= 1'b1;
                        we_q     <= !load_q;
                        baddr_q  <= addr2_q;
                        sel_q    <= sel2_q;
                        bwdata_q <= wdat2_q;
                    end else begin
                        state_q <= DONE;
                    end
                end
                RSP2: if (bus_rvalid_i) begin
                    // Beat 2 bytes continue the result after the NB-off bytes of beat 1
                    for (int o = 0; o < NB; o++) begin
                        if (o < int'(off_q) + nbq - NB)
                            rbuf_q[8*(NB-int'(off_q)+o) +: 8] <= bus_rdata_i[8*lane(o) +: 8];
                    end
                    err_q   <= bus_err_i;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        unique case (state_q)
            IDLE: if (ex_valid_i) begin
                wd_o        = wd_i;
                wdata_o     = wdata_i;
                wreg_o      = wreg_i & !(is_load_i | is_store_i);
                stall_req_o = is_load_i | is_store_i;
            end
            DONE: begin
                wd_o    = wd_q;
                wdata_o = ext;
                wreg_o  = wreg_q & load_q & !err_q;
            end
            default: begin
                wd_o        = wd_q;
                stall_req_o = 1'b1;
            end
        endcase
    end

    assign err_o       = err_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = baddr_q;
    assign bus_sel_o   = sel_q;
    assign bus_wdata_o = bwdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (32-bit, lane-swapped); a second
// instance with splitting disabled covers the misaligned-error path.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, is_load_i, is_store_i, unsigned_i, wreg_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, reg2_i, wdata_i;
    logic [4:0]  wd_i;
    logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    logic [4:0]  wd_o, ns_wd_o;
    logic        wreg_o, stall_req_o, err_o, bus_req_o, bus_we_o;
    logic        ns_wreg_o, ns_stall_o, ns_err_o, ns_req_o, ns_we_o;
    logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
    logic [31:0] ns_wdata_o, ns_addr_o, ns_bwdata_o;
    logic [3:0]  bus_sel_o, ns_sel_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit u_dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stall_req_o(stall_req_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    mem_access_unit #(.MISALIGN_SPLIT(1'b0)) u_ns (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .wd_o(ns_wd_o), .wreg_o(ns_wreg_o), .wdata_o(ns_wdata_o),
        .stall_req_o(ns_stall_o), .err_o(ns_err_o),
        .bus_req_o(ns_req_o), .bus_we_o(ns_we_o), .bus_addr_o(ns_addr_o),
        .bus_sel_o(ns_sel_o), .bus_wdata_o(ns_bwdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // New cycle: bus and upstream default to idle
    task automatic tick();
        @(posedge clk);
        #1;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
        ex_valid_i   = 1'b0;
    endtask

    task automatic issue(input string tag, input logic ld, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] r2);
        tick();
        ex_valid_i = 1'b1;
        is_load_i  = ld;
        is_store_i = !ld;
        size_i     = sz;
        unsigned_i = uns;
        addr_i     = a;
        reg2_i     = r2;
        wd_i       = 5'd5;
        wreg_i     = 1'b1;
        wdata_i    = 32'h0BAD_0BAD;
        @(negedge clk);
        chk({tag, "_T_stall"}, stall_req_o, 1);
        chk({tag, "_T_wreg"}, wreg_o, 0);
        chk({tag, "_T_req"}, bus_req_o, 0);
    endtask

    task automatic run_beat(input string tag, input int gdly, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] w, input logic we,
                            input logic [31:0] rd, input logic be);
        for (int c = 0; c <= gdly; c++) begin
            tick();
            bus_gnt_i = (c == gdly);
            @(negedge clk);
            chk({tag, "_req"}, bus_req_o, 1);
            chk({tag, "_addr"}, bus_addr_o, a);
            chk({tag, "_sel"}, bus_sel_o, s);
            chk({tag, "_wdata"}, bus_wdata_o, w);
            chk({tag, "_we"}, bus_we_o, we);
            chk({tag, "_stall"}, stall_req_o, 1);
        end
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rd;
        bus_err_i    = be;
        @(negedge clk);
        chk({tag, "_rsp_req"}, bus_req_o, 0);
        chk({tag, "_rsp_stall"}, stall_req_o, 1);
    endtask

    task automatic done_chk(input string tag, input logic [31:0] exp_d,
                            input logic exp_wreg, input logic exp_err);
        tick();
        @(negedge clk);
        chk({tag, "_done_stall"}, stall_req_o, 0);
        chk({tag, "_done_wreg"}, wreg_o, exp_wreg);
        chk({tag, "_done_err"}, err_o, exp_err);
        chk({tag, "_done_req"}, bus_req_o, 0);
        if (exp_wreg) begin
            chk({tag, "_done_wdata"}, wdata_o, exp_d);
            chk({tag, "_done_wd"}, wd_o, 5);
        end
    endtask

    initial begin
        rst = 1'b0;
        ex_valid_i = 0; is_load_i = 0; is_store_i = 0; unsigned_i = 0; wreg_i = 0;
        size_i = 0; addr_i = 0; reg2_i = 0; wdata_i = 0; wd_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0; bus_rdata_i = 0;
        #12;
        chk("rst_req", bus_req_o, 0);
        chk("rst_we", bus_we_o, 0);
        chk("rst_sel", bus_sel_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_bwdata", bus_wdata_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wd", wd_o, 0);
        chk("rst_wdata", wdata_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // Non-memory op passes straight through
        tick();
        ex_valid_i = 1; is_load_i = 0; is_store_i = 0;
        wd_i = 5'd7; wreg_i = 1; wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        chk("alu_wd", wd_o, 7);
        chk("alu_wreg", wreg_o, 1);
        chk("alu_wdata", wdata_o, 32'hCAFEF00D);
        chk("alu_stall", stall_req_o, 0);
        tick();
        @(negedge clk);
        chk("alu_novalid_wreg", wreg_o, 0);

        issue("lw", 1, 2, 0, 32'h100, 0);
        run_beat("lw_b1", 0, 32'h100, 4'b1111, 0, 0, 32'h78563412, 0);
        done_chk("lw", 32'h12345678, 1, 0);

        issue("lb", 1, 0, 0, 32'h103, 0);
        run_beat("lb_b1", 0, 32'h100, 4'b0001, 0, 0, 32'h000000F0, 0);
        done_chk("lb", 32'hFFFFFFF0, 1, 0);

        issue("lbu", 1, 0, 1, 32'h103, 0);
        run_beat("lbu_b1", 0, 32'h100, 4'b0001, 0, 0, 32'h000000F0, 0);
        done_chk("lbu", 32'h000000F0, 1, 0);

        issue("lh", 1, 1, 0, 32'h102, 0);
        run_beat("lh_b1", 1, 32'h100, 4'b0011, 0, 0, 32'h00000180, 0);
        done_chk("lh", 32'hFFFF8001, 1, 0);

        issue("sh", 0, 1, 0, 32'h102, 32'h0000BEEF);
        run_beat("sh_b1", 3, 32'h100, 4'b0011, 32'h0000EFBE, 1, 0, 0);
        done_chk("sh", 0, 0, 0);

        issue("sw", 0, 2, 0, 32'h101, 32'hAABBCCDD);
        run_beat("sw_b1", 0, 32'h100, 4'b0111, 32'h00DDCCBB, 1, 0, 0);
        run_beat("sw_b2", 1, 32'h104, 4'b1000, 32'hAA000000, 1, 0, 0);
        done_chk("sw", 0, 0, 0);

        // Misaligned LW: error on the no-split instance, two beats on the main one
        issue("lwm", 1, 2, 0, 32'h102, 0);
        tick();
        @(negedge clk);
        chk("ns_err_T1", ns_err_o, 1);
        chk("ns_req_T1", ns_req_o, 0);
        chk("ns_wreg_T1", ns_wreg_o, 0);
        chk("ns_stall_T1", ns_stall_o, 0);
        chk("lwm_req_T1", bus_req_o, 1);
        run_beat("lwm_b1", 0, 32'h100, 4'b0011, 0, 0, 32'h00002211, 0);
        run_beat("lwm_b2", 0, 32'h104, 4'b1100, 0, 0, 32'h44330000, 0);
        done_chk("lwm", 32'h33441122, 1, 0);
        chk("ns_err_cleared", ns_err_o, 0);

        issue("lwe", 1, 2, 0, 32'h102, 0);
        run_beat("lwe_b1", 0, 32'h100, 4'b0011, 0, 0, 32'h12345678, 1);
        done_chk("lwe", 0, 0, 1);
        tick();
        @(negedge clk);
        chk("lwe_no_b2", bus_req_o, 0);
        chk("lwe_err_pulse", err_o, 0);

        issue("ld32", 1, 3, 0, 32'h100, 0);
        done_chk("ld32", 0, 0, 1);

        // Reset while the request is outstanding
        issue("rq", 1, 2, 0, 32'h200, 0);
        tick();
        @(negedge clk);
        chk("rq_req", bus_req_o, 1);
        #1 rst = 1'b0;
        #1 chk("rq_async_req", bus_req_o, 0);
        #2 rst = 1'b1;

        // Reset while waiting for the response
        issue("rr", 1, 2, 0, 32'h200, 0);
        tick();
        bus_gnt_i = 1'b1;
        @(negedge clk);
        chk("rr_req", bus_req_o, 1);
        tick();
        @(negedge clk);
        chk("rr_rsp_stall", stall_req_o, 1);
        #1 rst = 1'b0;
        #1 chk("rr_async_req", bus_req_o, 0);
        chk("rr_async_stall", stall_req_o, 0);
        #2 rst = 1'b1;
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEADBEEF;
        @(negedge clk);
        chk("rr_late_wreg", wreg_o, 0);
        chk("rr_late_err", err_o, 0);
        tick();
        @(negedge clk);
        chk("rr_after_wreg", wreg_o, 0);
        chk("rr_after_err", err_o, 0);
        chk("rr_after_stall", stall_req_o, 0);

        issue("lw2", 1, 2, 0, 32'h100, 0);
        run_beat("lw2_b1", 0, 32'h100, 4'b1111, 0, 0, 32'h44332211, 0);
        done_chk("lw2", 32'h11223344, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
